// File: rtl/gray_code_tx.sv
// gray_code_tx: source-side event counter published as registered Gray code, with a four-phase clear handshake.
// Ports:
//   clk, resetn      source clock, asynchronous active-low reset
//   en, inc          count enable and single-cycle increment request
//   clr              clear request, honoured only while not busy
//   clr_ack          destination acknowledge (asynchronous, synchronized here)
//   clr_req          registered clear request to the destination
//   busy             clear handshake in progress
//   cnt_bin          registered binary count
//   cnt_gray         registered Gray image of cnt_bin for the crossing
//   wrap             one-cycle pulse on all-ones -> 0
//   ovf              sticky wrap flag, cleared by a clear
//   drop             sticky flag for increments discarded by a clear or while busy
module gray_code_tx #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  input  logic             clr_ack,
  output logic             clr_req,
  output logic             busy,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             wrap,
  output logic             ovf,
  output logic             drop
);
  typedef enum logic [1:0] {RUN, REQ, REL} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ack_sync;
  logic [WIDTH-1:0] r_bin, r_gray, w_bin_nxt;
  logic             r_req, r_wrap, r_ovf, r_drop;
  logic             w_wrap_nxt, w_ovf_nxt, w_drop_nxt, w_inc, w_ack_s;
  assign w_inc   = en & inc;
  assign w_ack_s = r_ack_sync[1];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_drop_nxt  = r_drop | w_inc;
    case (r_state)
      RUN: begin
        w_drop_nxt = r_drop;
        if (clr) begin
          // a coincident increment is lost, so drop is set even as the clear wipes the flags
          w_state_nxt = REQ;
          w_bin_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_drop_nxt  = w_inc;
        end else if (w_inc) begin
          w_bin_nxt  = r_bin + 1'b1;
          w_wrap_nxt = &r_bin;
          w_ovf_nxt  = r_ovf | (&r_bin);
        end
      end
      REQ:     w_state_nxt = w_ack_s ? REL : REQ;
      REL:     w_state_nxt = w_ack_s ? REL : RUN;
      default: w_state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ack_sync <= '0;
      r_bin      <= '0;
      r_gray     <= '0;
      r_req      <= 1'b0;
      r_wrap     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[0], clr_ack};
      r_bin      <= w_bin_nxt;
      r_gray     <= w_bin_nxt ^ (w_bin_nxt >> 1);
      r_req      <= (w_state_nxt == REQ);
      r_wrap     <= w_wrap_nxt;
      r_ovf      <= w_ovf_nxt;
      r_drop     <= w_drop_nxt;
    end
  end
  assign clr_req  = r_req;
  assign busy     = (r_state != RUN);
  assign cnt_bin  = r_bin;
  assign cnt_gray = r_gray;
  assign wrap     = r_wrap;
  assign ovf      = r_ovf;
  assign drop     = r_drop;
endmodule

// File: tb/tb_gray_code_tx.sv
// tb_gray_code_tx: directed and randomized checks of gray_code_tx against a behavioural model.
module tb_gray_code_tx;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic         clk = 1'b0, resetn = 1'b0;
  logic         en = 1'b0, inc = 1'b0, clr = 1'b0, clr_ack = 1'b0;
  logic         clr_req, busy, wrap, ovf, drop;
  logic [W-1:0] cnt_bin, cnt_gray;
  int n_checks = 0, n_errors = 0;
  int m_cnt;
  bit m_req, m_busy, m_wrap, m_ovf, m_drop, m_a1, m_a2;
  gray_code_tx #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .en(en), .inc(inc), .clr(clr), .clr_ack(clr_ack),
    .clr_req(clr_req), .busy(busy), .cnt_bin(cnt_bin), .cnt_gray(cnt_gray),
    .wrap(wrap), .ovf(ovf), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_req = 0; m_busy = 0; m_wrap = 0; m_ovf = 0; m_drop = 0; m_a1 = 0; m_a2 = 0;
  endtask
  task automatic model_edge();
    bit hit;
    hit = en & inc;
    m_wrap = 0;
    if (!m_busy) begin
      if (clr) begin
        m_cnt = 0; m_ovf = 0; m_drop = hit; m_req = 1; m_busy = 1;
      end else if (hit) begin
        m_wrap = (m_cnt == M - 1);
        m_cnt = (m_cnt + 1) % M;
        m_ovf = m_ovf | m_wrap;
      end
    end else begin
      if (hit) m_drop = 1;
      if (m_req && m_a2) m_req = 0;
      else if (!m_req && !m_a2) m_busy = 0;
    end
    m_a2 = m_a1;
    m_a1 = clr_ack;
  endtask
  task automatic compare_all();
    chk("cnt_bin", int'(cnt_bin), m_cnt);
    chk("cnt_gray", int'(cnt_gray), m_cnt ^ (m_cnt / 2));
    chk("clr_req", int'(clr_req), int'(m_req));
    chk("busy", int'(busy), int'(m_busy));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("drop", int'(drop), int'(m_drop));
  endtask
  task automatic cyc(input bit e, input bit i, input bit c, input bit a);
    en = e; inc = i; clr = c; clr_ack = a;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask
  task automatic handshake();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0);
  endtask
  int gtab[5] = '{1, 3, 2, 6, 7};
  int prev_gray;
  initial begin
    model_reset();
    #12;
    compare_all();
    resetn = 1'b1;
    prev_gray = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0);
      chk("count_seq", int'(cnt_bin), k + 1);
      chk("gray_seq", int'(cnt_gray), gtab[k]);
      chk("gray_1bit", $countones(prev_gray ^ int'(cnt_gray)), 1);
      prev_gray = int'(cnt_gray);
    end
    for (int k = 0; k < 9; k++) cyc(1, 1, 0, 0);
    chk("at14", int'(cnt_bin), 14);
    cyc(1, 1, 0, 0);
    chk("gray15", int'(cnt_gray), 8);
    chk("no_wrap15", int'(wrap), 0);
    cyc(1, 1, 0, 0);
    chk("wrap_cnt", int'(cnt_bin), 0);
    chk("wrap_gray", int'(cnt_gray), 0);
    chk("wrap_pulse", int'(wrap), 1);
    chk("ovf_set", int'(ovf), 1);
    cyc(0, 0, 0, 0);
    chk("wrap_one_cycle", int'(wrap), 0);
    chk("ovf_sticky", int'(ovf), 1);
    for (int k = 0; k < 9; k++) cyc(1, 1, 0, 0);
    chk("at9", int'(cnt_bin), 9);
    cyc(0, 0, 1, 0);
    chk("clr_cnt", int'(cnt_bin), 0);
    chk("clr_req_up", int'(clr_req), 1);
    chk("clr_busy", int'(busy), 1);
    cyc(0, 0, 0, 1);
    chk("req_hold1", int'(clr_req), 1);
    cyc(0, 0, 0, 1);
    chk("req_hold2", int'(clr_req), 1);
    cyc(0, 0, 0, 1);
    chk("req_fall", int'(clr_req), 0);
    chk("busy_rel", int'(busy), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("busy_hold", int'(busy), 1);
    cyc(0, 0, 0, 0);
    chk("busy_fall", int'(busy), 0);
    chk("ovf_cleared", int'(ovf), 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    chk("coll_cnt", int'(cnt_bin), 0);
    chk("coll_drop", int'(drop), 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 1);
    chk("busy_cnt", int'(cnt_bin), 0);
    chk("busy_drop", int'(drop), 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    chk("second_clr_ignored", int'(busy), 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    chk("no_extra_req", int'(clr_req), 0);
    cyc(0, 0, 1, 0);
    handshake();
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
    chk("en_gate_cnt", int'(cnt_bin), 2);
    chk("en_gate_drop", int'(drop), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    #20;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 1);
    chk("post_rst_cnt", int'(cnt_bin), 5);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_req", int'(clr_req), 0);
    cyc(0, 0, 1, 1);
    handshake();
    for (int k = 0; k < 3000; k++) begin
      bit a;
      a = clr_ack;
      if ($urandom_range(0, 2) == 0) a = m_req;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0, a);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
